// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a TX byte FIFO into back-to-back 8N1/8N2 frames.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1/8E2).
module uart_tx_fifo_drain #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg, tx_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          baud_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_reg, parity_next;
`endif

    // Reset gates the pop so nothing is consumed while the transmitter is held.
    assign fifo_rd_en = rst && (state_reg == IDLE) && !fifo_empty;
    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign tx_done    = done_reg;
    assign baud_end   = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: if (!fifo_empty) state_next = LOAD;
            LOAD: begin
                shift_next  = fifo_data;
                bit_next    = '0;
`ifdef UART_TX_PARITY_EN
                parity_next = ^fifo_data;
`endif
                state_next  = START;
            end
            START: if (baud_end) state_next = DATA;
            DATA: if (baud_end) begin
                shift_next = shift_reg >> 1;
                bit_next   = bit_reg + 3'd1;
                if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_end) state_next = STOP;
`endif
            // bit_reg wrapped to 0 after data bit 7, so it now counts stop bits.
            STOP: if (baud_end) begin
                if (bit_reg == STOP_LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    bit_next = bit_reg + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_reg == IDLE || state_next != state_reg || baud_end)
            baud_next = '0;
        else
            baud_next = baud_reg + CW'(1);

        // Line level is registered from the upcoming state so tx lines up with it.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_reg;
`endif
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

endmodule
